// File: rtl/debounce_counter.sv
// debounce_counter: pushbutton-driven up/down digit counter.
// Count_Button and Clear_Button are synchronized and debounced; Dir is
// synchronized only. Each accepted Count press steps Digit within
// 0..MAX_COUNT, wrapping with a one-cycle Wrap strobe. An accepted Clear
// press zeroes Digit and overrides a simultaneous Count press.
module debounce_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned MAX_COUNT       = 15
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       Count_Button,
    input  logic       Clear_Button,
    input  logic       Dir,
    output logic [3:0] Digit,
    output logic       Press_Pulse,
    output logic       Wrap
);

    localparam int unsigned       CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]        DIGIT_MAX = 4'(MAX_COUNT);

    // Bit order in the synchronizer: {Dir, Clear_Button, Count_Button}
    logic [2:0] sync_1;
    logic [2:0] sync_2;
    logic [1:0] rise;     // {clear_rise, count_rise}
    logic       dir_down;

    // Two-flop synchronizer for all three raw inputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= {Dir, Clear_Button, Count_Button};
            sync_2 <= sync_1;
        end
    end

    assign dir_down = sync_2[2];

    // One debouncer per button. The rising event is taken from the flip
    // condition itself, so the digit update lands on the same edge the
    // debounced state rises; this keeps total latency at DEBOUNCE_CYCLES+2.
    for (genvar g = 0; g < 2; g++) begin : g_deb
        logic [CNT_W-1:0] cnt;
        logic             state;
        logic             differ;
        logic             flip;

        assign differ  = (sync_2[g] != state);
        assign flip    = differ && (cnt == CNT_LAST);
        assign rise[g] = flip && !state;

        // Mismatch counter: cleared on agreement, flips the state at the limit
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                cnt   <= '0;
                state <= 1'b0;
            end else if (!differ) begin
                cnt   <= '0;
            end else if (flip) begin
                cnt   <= '0;
                state <= ~state;
            end else begin
                cnt   <= cnt + 1'b1;
            end
        end
    end

    // Digit update and strobes; Clear wins over a coincident Count press
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Digit       <= '0;
            Press_Pulse <= 1'b0;
            Wrap        <= 1'b0;
        end else begin
            Press_Pulse <= 1'b0;
            Wrap        <= 1'b0;
            if (rise[1]) begin
                Digit <= '0;
            end else if (rise[0]) begin
                Press_Pulse <= 1'b1;
                if (dir_down) begin
                    if (Digit == 4'd0) begin
                        Digit <= DIGIT_MAX;
                        Wrap  <= 1'b1;
                    end else begin
                        Digit <= Digit - 4'd1;
                    end
                end else begin
                    if (Digit >= DIGIT_MAX) begin
                        Digit <= '0;
                        Wrap  <= 1'b1;
                    end else begin
                        Digit <= Digit + 4'd1;
                    end
                end
            end
        end
    end

endmodule
